// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size encodings,
// controller state type and the alignment check used on every request.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // A request faults when its size is reserved or its byte offset does not
    // match the natural alignment of the access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// Request/response bundle between the MEM-stage pipeline and the data memory.
interface data_memory_controller_if;

    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  access_size;
    logic        load_unsigned;
    logic [31:0] data_write;
    logic [31:0] read_data;
    logic        read_valid;
    logic        misaligned_fault;
    logic        busy;

    modport master (
        output address, mem_read, mem_write, access_size, load_unsigned, data_write,
        input  read_data, read_valid, misaligned_fault, busy
    );

    modport slave (
        input  address, mem_read, mem_write, access_size, load_unsigned, data_write,
        output read_data, read_valid, misaligned_fault, busy
    );

endinterface

// File: rtl/data_memory_controller_load_align_unit.sv
// Combinational load formatter: picks the big-endian lane addressed by the
// byte offset and sign- or zero-extends it to 32 bits.
module load_align_unit
    import mem_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] result
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_sx;
    logic signed [31:0] half_sx;

    // Lane selection and extension; offset 0 is the most significant lane.
    always_comb begin
        byte_s = '0;
        case (offset)
            2'd0:    byte_s = raw_word[31:24];
            2'd1:    byte_s = raw_word[23:16];
            2'd2:    byte_s = raw_word[15:8];
            default: byte_s = raw_word[7:0];
        endcase
        half_s  = offset[1] ? raw_word[15:0] : raw_word[31:16];
        byte_sx = byte_s;
        half_sx = half_s;
        result  = raw_word;
        case (size)
            SIZE_BYTE: result = load_unsigned ? {24'b0, byte_s} : byte_sx;
            SIZE_HALF: result = load_unsigned ? {16'b0, half_s} : half_sx;
            default:   result = raw_word;
        endcase
    end

endmodule

// File: rtl/data_memory_controller.sv
// MEM-stage data memory: byte/half/word big-endian loads and stores, one-cycle
// registered load results, alignment faults, and a post-reset clear sweep
// that holds busy until every word has been zeroed.
module data_memory_controller
    import mem_pkg::*;
#(
    parameter int WORD_ADDR_BITS = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    data_memory_controller_if.slave  bus
);

    localparam int DEPTH = 2 ** WORD_ADDR_BITS;

    logic [31:0] mem [DEPTH];

    state_t                    state, state_nxt;
    logic [WORD_ADDR_BITS-1:0] clr_cnt;
    logic                      busy_c;
    logic                      clr_we;

    logic [WORD_ADDR_BITS-1:0] word_idx;
    logic [1:0]                offset;
    logic                      misal;
    logic                      load_c;
    logic                      store_c;
    logic                      fault_c;
    logic [3:0]                be;
    logic [31:0]               lane_data;
    logic [31:0]               load_res;

    logic [31:0]               rdata_p1;
    logic                      vld_p1;
    logic                      fault_p1;

    // Upper address bits alias onto the array and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address[31:WORD_ADDR_BITS+2];

    assign word_idx = bus.address[WORD_ADDR_BITS+1:2];
    assign offset   = bus.address[1:0];
    assign misal    = is_misaligned(bus.access_size, offset);
    assign load_c   = bus.mem_read  & ~busy_c & ~misal;
    assign store_c  = bus.mem_write & ~busy_c & ~misal;
    assign fault_c  = (bus.mem_read | bus.mem_write) & ~busy_c & misal;

    // State register and clear counter; reset restarts the sweep at word 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Next state: leave CLEAR on the cycle that writes the last word.
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_cnt == WORD_ADDR_BITS'(DEPTH - 1)) state_nxt = ST_IDLE;
    end

    // FSM outputs: busy and the clear write enable follow the CLEAR state.
    always_comb begin
        busy_c = (state == ST_CLEAR);
        clr_we = (state == ST_CLEAR);
    end

    // Store byte enables and lane-replicated data, big-endian lane order.
    always_comb begin
        be        = '0;
        lane_data = '0;
        case (bus.access_size)
            SIZE_BYTE: begin
                be        = 4'b1000 >> offset;
                lane_data = {4{bus.data_write[7:0]}};
            end
            SIZE_HALF: begin
                be        = offset[1] ? 4'b0011 : 4'b1100;
                lane_data = {2{bus.data_write[15:0]}};
            end
            SIZE_WORD: begin
                be        = 4'b1111;
                lane_data = bus.data_write;
            end
            default: ;
        endcase
    end

    // Array write port shared between the clear sweep and byte-lane stores.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (store_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
            end
        end
    end

    load_align_unit u_align (
        .raw_word      (mem[word_idx]),
        .offset        (offset),
        .size          (bus.access_size),
        .load_unsigned (bus.load_unsigned),
        .result        (load_res)
    );

    // Stage p1: registered load result, valid strobe and fault strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
            fault_p1 <= 1'b0;
        end else begin
            vld_p1   <= load_c;
            fault_p1 <= fault_c;
            if (load_c) rdata_p1 <= load_res;
        end
    end

    assign bus.read_data        = rdata_p1;
    assign bus.read_valid       = vld_p1;
    assign bus.misaligned_fault = fault_p1;
    assign bus.busy             = busy_c;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller with a 16-word array: clear
// sweep, lane placement, extension, faults, read/write collision and
// reset during the clear sweep.
module tb_data_memory_controller;
    import mem_pkg::*;

    typedef struct packed {
        logic        v;
        logic        f;
        logic [31:0] d;
    } exp_t;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;
    logic [31:0] last_data;
    exp_t sb [$];

    data_memory_controller_if bus ();

    data_memory_controller #(
        .WORD_ADDR_BITS (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic ev, input logic ef, input logic [31:0] ed);
        exp_t e;
        bus.address       = addr;
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.access_size   = sz;
        bus.load_unsigned = uns;
        bus.data_write    = wd;
        e.v = ev;
        e.f = ef;
        e.d = ev ? ed : last_data;
        if (ev) last_data = ed;
        sb.push_back(e);
        @(posedge clock);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        e = sb.pop_front();
        chk({tag, ".valid"}, {31'b0, bus.read_valid}, {31'b0, e.v});
        chk({tag, ".fault"}, {31'b0, bus.misaligned_fault}, {31'b0, e.f});
        chk({tag, ".data"}, bus.read_data, e.d);
    endtask

    task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        req(tag, 1'b0, 1'b1, sz, 1'b0, addr, wd, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] exp);
        req(tag, 1'b1, 1'b0, sz, uns, addr, 32'h0, 1'b1, 1'b0, exp);
    endtask

    task automatic flt(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
        req(tag, rd, wr, sz, 1'b0, addr, wd, 1'b0, 1'b1, 32'h0);
    endtask

    // Counts busy cycles after reset release; strobes must stay low throughout.
    task automatic count_busy(input string tag);
        int cyc;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.busy === 1'b1) begin
                chk({tag, ".busy_valid"}, {31'b0, bus.read_valid}, 32'h0);
                chk({tag, ".busy_fault"}, {31'b0, bus.misaligned_fault}, 32'h0);
            end
        end
        chk({tag, ".busy_cycles"}, cyc, 32'd16);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        last_data = 32'h0;
        reset = 1'b1;
        bus.address = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.access_size = SIZE_WORD;
        bus.load_unsigned = 1'b0;
        bus.data_write = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst.busy", {31'b0, bus.busy}, 32'h1);
        chk("rst.data", bus.read_data, 32'h0);
        chk("rst.valid", {31'b0, bus.read_valid}, 32'h0);
        chk("rst.fault", {31'b0, bus.misaligned_fault}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        count_busy("clr1");

        for (int i = 0; i < 16; i++) ld($sformatf("clr1.w%0d", i), SIZE_WORD, 1'b0, 32'(i * 4), 32'h0);

        // Big-endian byte lanes
        st("sw8", SIZE_WORD, 32'h8, 32'h12345678);
        ld("lb8", SIZE_BYTE, 1'b0, 32'h8, 32'h00000012);
        ld("lb9", SIZE_BYTE, 1'b0, 32'h9, 32'h00000034);
        ld("lbA", SIZE_BYTE, 1'b0, 32'hA, 32'h00000056);
        ld("lbB", SIZE_BYTE, 1'b0, 32'hB, 32'h00000078);
        st("sw8f0", SIZE_WORD, 32'h8, 32'h00F00000);
        ld("lb9s", SIZE_BYTE, 1'b0, 32'h9, 32'hFFFFFFF0);
        ld("lb9u", SIZE_BYTE, 1'b1, 32'h9, 32'h000000F0);

        // Partial stores preserve other lanes
        st("sw10", SIZE_WORD, 32'h10, 32'hAABBCCDD);
        st("sb12", SIZE_BYTE, 32'h12, 32'h00000011);
        ld("lw10a", SIZE_WORD, 1'b0, 32'h10, 32'hAABB11DD);
        st("sh10", SIZE_HALF, 32'h10, 32'h00008001);
        ld("lh10s", SIZE_HALF, 1'b0, 32'h10, 32'hFFFF8001);
        ld("lh10u", SIZE_HALF, 1'b1, 32'h10, 32'h00008001);
        ld("lh12", SIZE_HALF, 1'b0, 32'h12, 32'h000011DD);
        ld("lw10b", SIZE_WORD, 1'b0, 32'h10, 32'h800111DD);

        // Faults: no write, no strobe, data held, one-cycle pulse
        flt("f_sw6", 1'b0, 1'b1, SIZE_WORD, 32'h6, 32'hDEADBEEF);
        req("f_idle", 1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        ld("lw4", SIZE_WORD, 1'b0, 32'h4, 32'h0);
        flt("f_lh3", 1'b1, 1'b0, SIZE_HALF, 32'h3, 32'h0);
        flt("f_rsvd", 1'b1, 1'b0, SIZE_RSVD, 32'h0, 32'h0);
        flt("f_rsvdw", 1'b0, 1'b1, SIZE_RSVD, 32'h0, 32'hFFFFFFFF);
        ld("lw0", SIZE_WORD, 1'b0, 32'h0, 32'h0);

        // Read+write collision returns old contents
        st("sw20", SIZE_WORD, 32'h20, 32'h00000001);
        req("rw20", 1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h00000002, 1'b1, 1'b0, 32'h00000001);
        ld("lw20", SIZE_WORD, 1'b0, 32'h20, 32'h00000002);

        // Upper address bits alias onto the array
        ld("alias", SIZE_WORD, 1'b0, 32'h48, 32'h00F00000);

        // Reset during the sweep restarts it; requests while busy are ignored
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        last_data = 32'h0;
        #1;
        chk("rst2.busy", {31'b0, bus.busy}, 32'h1);
        chk("rst2.data", bus.read_data, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        bus.address = 32'h8;
        bus.mem_read = 1'b1;
        bus.mem_write = 1'b1;
        bus.access_size = SIZE_WORD;
        bus.data_write = 32'hFFFFFFFF;
        count_busy("clr2");
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        for (int i = 0; i < 16; i++) ld($sformatf("clr2.w%0d", i), SIZE_WORD, 1'b0, 32'(i * 4), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
